// File: rtl/hwag_core.sv
// -----------------------------------------------------------------------------
// hwag_core - hardware angle generator front-end for a 60-2 crank wheel.
//
// Digitally filters the VR comparator input, measures the tooth period,
// detects the missing-tooth gap, counts teeth and raises a maskable level
// interrupt. Configuration and status go through a 16-bit synchronous
// register port with a bidirectional data bus.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous reset, active low
//   ssram_we    register write strobe (write happens on the clock edge)
//   ssram_re    register read strobe (read data driven combinationally)
//   ssram_addr  register word address
//   ssram_data  bidirectional register data, Z unless a read is active
//   vr_in       raw VR comparator input (asynchronous)
//   vr_out      filtered VR signal
//   hwagif      interrupt request, level
//
// Register map (16-bit words):
//   0x00..0x3F  RAM, R/W; word 0x00 doubles as FILT (filter length)
//   0x40 HWACR0 R/W  [0] EN, [1] FEN, [2] EDGE (1 = rising edge is a tooth)
//   0x41 HWASR  R/W1C [0] GAPF, [1] OVFF, [2] SYNC (read only)
//   0x42 HWAIER R/W  [0] gap IE, [1] overflow IE
//   0x43 TCNT   R    tooth index
//   0x44 PCNT   R    running period counter
//   0x45 TPER   R    last captured tooth period
//   others      read 0, writes ignored
// -----------------------------------------------------------------------------
module hwag_core #(
  parameter int FILT_W = 16,
  parameter int PCNT_W = 16,
  parameter int TEETH  = 58
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ssram_we,
  input  logic        ssram_re,
  input  logic [7:0]  ssram_addr,
  inout  wire  [15:0] ssram_data,
  input  logic        vr_in,
  output logic        vr_out,
  output logic        hwagif
);

  localparam int TCNT_W = $clog2(TEETH);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TEETH - 1);
  localparam logic [PCNT_W-1:0] PCNT_ALL = {PCNT_W{1'b1}};
  // Value one below saturation: the increment from here is the overflow moment.
  localparam logic [PCNT_W-1:0] PCNT_PRE = {{(PCNT_W-1){1'b1}}, 1'b0};

  localparam logic [7:0] ADDR_ACR  = 8'h40;
  localparam logic [7:0] ADDR_SR   = 8'h41;
  localparam logic [7:0] ADDR_IER  = 8'h42;
  localparam logic [7:0] ADDR_TCNT = 8'h43;
  localparam logic [7:0] ADDR_PCNT = 8'h44;
  localparam logic [7:0] ADDR_TPER = 8'h45;

  // Register storage
  logic [15:0]       ram_r [0:63];
  logic [2:0]        acr_r;
  logic [1:0]        ier_r;
  logic              gapf_r;
  logic              ovff_r;
  logic              sync_r;
  logic [TCNT_W-1:0] tcnt_r;
  logic [PCNT_W-1:0] pcnt_r;
  logic [PCNT_W-1:0] tper_r;

  // VR path
  logic              sync1_r;
  logic              sync2_r;
  logic [FILT_W-1:0] fcnt_r;
  logic              vr_out_r;
  logic              vr_d_r;
  logic              hwagif_r;

  // Decoded control
  logic              en_s;
  logic              fen_s;
  logic              edge_sel_s;
  logic [FILT_W-1:0] filt_s;
  logic              ram_wr_s;
  logic              acr_wr_s;
  logic              ier_wr_s;
  logic [1:0]        w1c_s;
  logic              rise_s;
  logic              fall_s;
  logic              tooth_s;
  logic              gap_s;
  logic              ovf_set_s;
  logic              drive_s;
  logic [15:0]       rdata_s;

  assign en_s       = acr_r[0];
  assign fen_s      = acr_r[1];
  assign edge_sel_s = acr_r[2];
  assign filt_s     = ram_r[0][FILT_W-1:0];

  assign ram_wr_s = ssram_we && (ssram_addr[7:6] == 2'b00);
  assign acr_wr_s = ssram_we && (ssram_addr == ADDR_ACR);
  assign ier_wr_s = ssram_we && (ssram_addr == ADDR_IER);
  assign w1c_s    = (ssram_we && (ssram_addr == ADDR_SR)) ? ssram_data[1:0] : 2'b00;

  // Tooth event: one-cycle pulse on the selected edge of the filtered signal.
  assign rise_s  = vr_out_r & ~vr_d_r;
  assign fall_s  = ~vr_out_r & vr_d_r;
  assign tooth_s = en_s & (edge_sel_s ? rise_s : fall_s);

  // Gap compares against twice the previous period; one extra bit avoids
  // losing the top bit of 2*TPER.
  assign gap_s = tooth_s && (tper_r != {PCNT_W{1'b0}}) &&
                 ({1'b0, pcnt_r} > {tper_r, 1'b0});

  // Overflow fires only on the step into saturation, so a W1C can clear it
  // while the counter sits at all-ones. A tooth in that same clock wins.
  assign ovf_set_s = en_s && !tooth_s && (pcnt_r == PCNT_PRE);

  // Bus driven only for a pure read; a simultaneous write keeps it released.
  assign drive_s    = ssram_re && !ssram_we;
  assign ssram_data = drive_s ? rdata_s : 16'hzzzz;

  assign vr_out = vr_out_r;
  assign hwagif = hwagif_r;

  // Read data multiplexer
  always_comb begin
    rdata_s = 16'h0000;
    if (ssram_addr[7:6] == 2'b00) begin
      rdata_s = ram_r[ssram_addr[5:0]];
    end else begin
      case (ssram_addr)
        ADDR_ACR:  rdata_s = {13'h0000, acr_r};
        ADDR_SR:   rdata_s = {13'h0000, sync_r, ovff_r, gapf_r};
        ADDR_IER:  rdata_s = {14'h0000, ier_r};
        ADDR_TCNT: rdata_s = 16'(tcnt_r);
        ADDR_PCNT: rdata_s = 16'(pcnt_r);
        ADDR_TPER: rdata_s = 16'(tper_r);
        default:   rdata_s = 16'h0000;
      endcase
    end
  end

  // RAM words and the writable control registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) begin
        ram_r[i] <= 16'h0000;
      end
      acr_r <= 3'b000;
      ier_r <= 2'b00;
    end else begin
      if (ram_wr_s) begin
        ram_r[ssram_addr[5:0]] <= ssram_data;
      end
      if (acr_wr_s) begin
        acr_r <= ssram_data[2:0];
      end
      if (ier_wr_s) begin
        ier_r <= ssram_data[1:0];
      end
    end
  end

  // VR synchroniser and glitch filter
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      fcnt_r   <= {FILT_W{1'b0}};
      vr_out_r <= 1'b0;
      vr_d_r   <= 1'b0;
    end else begin
      sync1_r <= vr_in;
      sync2_r <= sync1_r;
      vr_d_r  <= vr_out_r;
      if (!fen_s) begin
        vr_out_r <= sync2_r;
        fcnt_r   <= {FILT_W{1'b0}};
      end else if (sync2_r == vr_out_r) begin
        fcnt_r <= {FILT_W{1'b0}};
      end else if (fcnt_r >= filt_s) begin
        // FILT+1 consecutive differing clocks seen (counts 0..FILT)
        vr_out_r <= sync2_r;
        fcnt_r   <= {FILT_W{1'b0}};
      end else begin
        fcnt_r <= fcnt_r + FILT_W'(1);
      end
    end
  end

  // Period measurement, tooth counting and sync tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt_r <= {PCNT_W{1'b0}};
      tper_r <= {PCNT_W{1'b0}};
      tcnt_r <= {TCNT_W{1'b0}};
      sync_r <= 1'b0;
    end else if (!en_s) begin
      pcnt_r <= {PCNT_W{1'b0}};
      tper_r <= {PCNT_W{1'b0}};
      tcnt_r <= {TCNT_W{1'b0}};
      sync_r <= 1'b0;
    end else if (tooth_s) begin
      tper_r <= pcnt_r;
      pcnt_r <= PCNT_W'(1);
      if (gap_s) begin
        tcnt_r <= {TCNT_W{1'b0}};
        sync_r <= 1'b1;
      end else if (tcnt_r == TCNT_MAX) begin
        // Too many teeth without a gap: the wheel position is no longer trusted.
        sync_r <= 1'b0;
      end else begin
        tcnt_r <= tcnt_r + TCNT_W'(1);
      end
    end else if (pcnt_r != PCNT_ALL) begin
      pcnt_r <= pcnt_r + PCNT_W'(1);
      if (pcnt_r == PCNT_PRE) begin
        sync_r <= 1'b0;
        tcnt_r <= {TCNT_W{1'b0}};
      end
    end
  end

  // Status flags: a hardware set beats a same-cycle write-1-to-clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      gapf_r <= 1'b0;
      ovff_r <= 1'b0;
    end else begin
      gapf_r <= gap_s | (gapf_r & ~w1c_s[0]);
      ovff_r <= ovf_set_s | (ovff_r & ~w1c_s[1]);
    end
  end

  // Registered interrupt request
  always_ff @(posedge clk) begin
    if (!rst) begin
      hwagif_r <= 1'b0;
    end else begin
      hwagif_r <= |({ovff_r, gapf_r} & ier_r);
    end
  end

endmodule

// File: tb/tb_hwag_core.sv
// -----------------------------------------------------------------------------
// tb_hwag_core - directed self-checking bench for hwag_core.
// Inputs change just after the falling clock edge; outputs are sampled there
// too, away from the rising edge the design uses.
// -----------------------------------------------------------------------------
module tb_hwag_core;

  logic        clk;
  logic        rst;
  logic        ssram_we;
  logic        ssram_re;
  logic [7:0]  ssram_addr;
  wire  [15:0] ssram_data;
  logic        vr_in;
  logic        vr_out;
  logic        hwagif;

  logic [15:0] tb_data;
  logic        tb_drive;

  int tests;
  int fails;

  assign ssram_data = tb_drive ? tb_data : 16'hzzzz;

  hwag_core dut (
    .clk        (clk),
    .rst        (rst),
    .ssram_we   (ssram_we),
    .ssram_re   (ssram_re),
    .ssram_addr (ssram_addr),
    .ssram_data (ssram_data),
    .vr_in      (vr_in),
    .vr_out     (vr_out),
    .hwagif     (hwagif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write one word; consumes one clock.
  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    ssram_addr = a;
    tb_data    = d;
    tb_drive   = 1'b1;
    ssram_we   = 1'b1;
    @(negedge clk);
    ssram_we   = 1'b0;
    tb_drive   = 1'b0;
  endtask

  // Combinational read; consumes no clock (1 time unit).
  task automatic rd(input logic [7:0] a, output logic [15:0] d);
    ssram_addr = a;
    ssram_re   = 1'b1;
    #1;
    d = ssram_data;
    ssram_re = 1'b0;
  endtask

  // Drive vr_in to a level for n clocks.
  task automatic hold(input logic lvl, input int n);
    vr_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int a = 8'h40; a <= 8'h45; a++) begin
      @(negedge clk);
      rd(8'(a), v);
      tests++;
      if (v !== 16'h0000) begin
        fails++;
        $display("FAIL reset_reg[%h]: got %h expected 0000", a, v);
      end
    end
    tests++;
    if (vr_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_vr_out: got %b expected 0", vr_out);
    end
    tests++;
    if (hwagif !== 1'b0) begin
      fails++;
      $display("FAIL reset_hwagif: got %b expected 0", hwagif);
    end
    tests++;
    if (!((ssram_data === 16'hzzzz) || (ssram_data === 16'h0000))) begin
      fails++;
      $display("FAIL reset_bus_z: got %h expected released", ssram_data);
    end
  endtask

  task automatic test_regs();
    logic [15:0] v;
    @(negedge clk);
    wr(8'h00, 16'h0003);
    wr(8'h40, 16'h0007);
    wr(8'h42, 16'h0002);
    wr(8'h3F, 16'hA5C3);
    wr(8'h50, 16'hFFFF);
    wr(8'h45, 16'h1234);
    rd(8'h00, v);
    tests++;
    if (v !== 16'h0003) begin fails++; $display("FAIL reg_filt: got %h expected 0003", v); end
    rd(8'h40, v);
    tests++;
    if (v !== 16'h0007) begin fails++; $display("FAIL reg_acr: got %h expected 0007", v); end
    rd(8'h42, v);
    tests++;
    if (v !== 16'h0002) begin fails++; $display("FAIL reg_ier: got %h expected 0002", v); end
    @(negedge clk);
    rd(8'h3F, v);
    tests++;
    if (v !== 16'hA5C3) begin fails++; $display("FAIL reg_ram3f: got %h expected a5c3", v); end
    rd(8'h50, v);
    tests++;
    if (v !== 16'h0000) begin fails++; $display("FAIL reg_unmapped: got %h expected 0000", v); end
    rd(8'h45, v);
    tests++;
    if (v !== 16'h0000) begin fails++; $display("FAIL reg_tper_ro: got %h expected 0000", v); end
    // Addressed word is nonzero, but with re=0 the bus must stay released.
    ssram_addr = 8'h40;
    #1;
    tests++;
    if (!((ssram_data === 16'hzzzz) || (ssram_data === 16'h0000))) begin
      fails++;
      $display("FAIL reg_bus_idle: got %h expected released", ssram_data);
    end
  endtask

  task automatic test_filter();
    logic seen;
    @(negedge clk);
    hold(1'b0, 10);
    // 2-clock glitch must be swallowed by a FILT=3 filter
    hold(1'b1, 2);
    vr_in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vr_out !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin fails++; $display("FAIL filter_glitch: got vr_out=1 expected 0"); end
    // Steady high: 2 synchroniser clocks + 4 filter clocks
    vr_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 5) begin
        tests++;
        if (vr_out !== 1'b0) begin fails++; $display("FAIL filter_early: got %b expected 0", vr_out); end
      end
      if (i == 6) begin
        tests++;
        if (vr_out !== 1'b1) begin fails++; $display("FAIL filter_rise: got %b expected 1", vr_out); end
      end
    end
  endtask

  task automatic test_wheel();
    logic [15:0] v;
    hold(1'b0, 10);
    wr(8'h40, 16'h0000);
    wr(8'h41, 16'h0007);
    wr(8'h40, 16'h0007);
    hold(1'b0, 200);
    repeat (3) begin
      hold(1'b1, 128);
      hold(1'b0, 128);
    end
    // Normal tooth: period 256 captured, no gap yet
    hold(1'b1, 20);
    rd(8'h45, v);
    tests++;
    if (v !== 16'd256) begin fails++; $display("FAIL wheel_tper_normal: got %0d expected 256", v); end
    rd(8'h41, v);
    tests++;
    if (v !== 16'h0000) begin fails++; $display("FAIL wheel_sr_pregap: got %h expected 0000", v); end
    hold(1'b1, 108);
    hold(1'b0, 640);
    // Rising edge closing the 768-clock gap
    hold(1'b1, 20);
    rd(8'h41, v);
    tests++;
    if (v !== 16'h0005) begin fails++; $display("FAIL wheel_gap_sr: got %h expected 0005", v); end
    rd(8'h43, v);
    tests++;
    if (v !== 16'h0000) begin fails++; $display("FAIL wheel_gap_tcnt: got %0d expected 0", v); end
    rd(8'h45, v);
    tests++;
    if (v !== 16'd768) begin fails++; $display("FAIL wheel_gap_tper: got %0d expected 768", v); end
    wr(8'h41, 16'h0001);
    hold(1'b1, 107);
    hold(1'b0, 128);
    for (int k = 1; k <= 57; k++) begin
      hold(1'b1, 20);
      if (k == 1) begin
        rd(8'h43, v);
        tests++;
        if (v !== 16'd1) begin fails++; $display("FAIL wheel_tcnt1: got %0d expected 1", v); end
      end
      if (k == 57) begin
        rd(8'h43, v);
        tests++;
        if (v !== 16'd57) begin fails++; $display("FAIL wheel_tcnt57: got %0d expected 57", v); end
        rd(8'h45, v);
        tests++;
        if (v !== 16'd256) begin fails++; $display("FAIL wheel_tper57: got %0d expected 256", v); end
        rd(8'h41, v);
        tests++;
        if (v !== 16'h0004) begin fails++; $display("FAIL wheel_sr57: got %h expected 0004", v); end
        hold(1'b1, 108);
        hold(1'b0, 640);
      end else begin
        hold(1'b1, 108);
        hold(1'b0, 128);
      end
    end
    // Second gap
    hold(1'b1, 20);
    rd(8'h41, v);
    tests++;
    if (v !== 16'h0005) begin fails++; $display("FAIL wheel_gap2_sr: got %h expected 0005", v); end
    rd(8'h43, v);
    tests++;
    if (v !== 16'h0000) begin fails++; $display("FAIL wheel_gap2_tcnt: got %0d expected 0", v); end
    hold(1'b1, 108);
  endtask

  task automatic test_overflow();
    logic [15:0] v;
    vr_in = 1'b0;
    wr(8'h42, 16'h0002);
    wr(8'h41, 16'h0001);
    hold(1'b0, 65600);
    rd(8'h41, v);
    tests++;
    if (v !== 16'h0002) begin fails++; $display("FAIL ovf_sr: got %h expected 0002", v); end
    rd(8'h43, v);
    tests++;
    if (v !== 16'h0000) begin fails++; $display("FAIL ovf_tcnt: got %0d expected 0", v); end
    tests++;
    if (hwagif !== 1'b1) begin fails++; $display("FAIL ovf_irq: got %b expected 1", hwagif); end
    wr(8'h41, 16'h0002);
    rd(8'h41, v);
    tests++;
    if (v !== 16'h0000) begin fails++; $display("FAIL ovf_w1c: got %h expected 0000", v); end
    @(negedge clk);
    tests++;
    if (hwagif !== 1'b0) begin fails++; $display("FAIL ovf_irq_clr: got %b expected 0", hwagif); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    ssram_addr = 8'h42;
    tb_data    = 16'h0001;
    tb_drive   = 1'b1;
    ssram_we   = 1'b1;
    ssram_re   = 1'b1;
    #1;
    tb_drive = 1'b0;
    #1;
    tests++;
    if (!((ssram_data === 16'hzzzz) || (ssram_data === 16'h0000))) begin
      fails++;
      $display("FAIL both_bus: got %h expected released", ssram_data);
    end
    tb_drive = 1'b1;
    @(negedge clk);
    ssram_we = 1'b0;
    ssram_re = 1'b0;
    tb_drive = 1'b0;
    rd(8'h42, v);
    tests++;
    if (v !== 16'h0001) begin fails++; $display("FAIL both_ier: got %h expected 0001", v); end
    @(negedge clk);
    tests++;
    if (hwagif !== 1'b0) begin fails++; $display("FAIL both_irq: got %b expected 0", hwagif); end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rst        = 1'b0;
    ssram_we   = 1'b0;
    ssram_re   = 1'b0;
    ssram_addr = 8'h00;
    tb_data    = 16'h0000;
    tb_drive   = 1'b0;
    vr_in      = 1'b0;
    @(negedge clk);
    test_reset();
    test_regs();
    test_filter();
    test_wheel();
    test_overflow();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
